// File: rtl/ks_voice_ctrl.sv
// Karplus-Strong voice sequencer: noise fill, then a read/filter/write-back loop
// over the delay line. Define RETRIGGER_EN to let note_on abort a running note.
module ks_voice_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned SMP_DIV = 4,
  parameter int unsigned DURW    = 16
) (
  input  logic            i_clok,
  input  logic            i_rst,
  input  logic            i_note_on,
  input  logic [AW-1:0]   i_note_len,
  input  logic [DURW-1:0] i_note_dur,
  output logic            o_busy,
  output logic            o_done,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_we,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic [DW-1:0]   o_flt_in,
  input  logic [DW-1:0]   i_flt_out,
  output logic [DW-1:0]   o_smp_out,
  output logic            o_smp_valid
);

  localparam int unsigned Div = (SMP_DIV < 4) ? 4 : SMP_DIV;
  localparam int unsigned PhW = $clog2(Div);
  localparam logic [PhW-1:0] PhRead  = PhW'(1);
  localparam logic [PhW-1:0] PhWrite = PhW'(3);
  localparam logic [PhW-1:0] PhLast  = PhW'(Div - 1);

  typedef enum logic [1:0] {StIdle, StFill, StPlay, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_ptr, w_ptr_nxt;
  logic [AW-1:0]   r_n, w_n_nxt;
  logic [DURW-1:0] r_dur, w_dur_nxt;
  logic [DURW-1:0] r_cnt, w_cnt_nxt;
  logic [PhW-1:0]  r_ph, w_ph_nxt;
  logic [15:0]     r_lfsr, w_lfsr_nxt;
  logic [DW-1:0]   r_flt_in, w_flt_in_nxt;
  logic [DW-1:0]   r_smp_out, w_smp_out_nxt;
  logic            r_smp_valid, w_smp_valid_nxt;
  logic            w_start;
  logic [AW-1:0]   w_len_clamp;
  logic [AW-1:0]   w_ptr_wrap;

  assign w_len_clamp = (i_note_len < AW'(2)) ? AW'(2) : i_note_len;
  assign w_ptr_wrap  = (r_ptr == r_n - AW'(1)) ? '0 : r_ptr + AW'(1);

  always_ff @(posedge i_clok) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_n         <= '0;
      r_dur       <= '0;
      r_cnt       <= '0;
      r_ph        <= '0;
      r_lfsr      <= 16'hACE1;
      r_flt_in    <= '0;
      r_smp_out   <= '0;
      r_smp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_n         <= w_n_nxt;
      r_dur       <= w_dur_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ph        <= w_ph_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_flt_in    <= w_flt_in_nxt;
      r_smp_out   <= w_smp_out_nxt;
      r_smp_valid <= w_smp_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_n_nxt         = r_n;
    w_dur_nxt       = r_dur;
    w_cnt_nxt       = r_cnt;
    w_ph_nxt        = r_ph;
    w_lfsr_nxt      = r_lfsr;
    w_flt_in_nxt    = r_flt_in;
    w_smp_out_nxt   = r_smp_out;
    w_smp_valid_nxt = 1'b0;
    w_start         = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_addr      = '0;
    o_mem_wdata     = '0;
    o_done          = 1'b0;
    o_busy          = (r_state != StIdle);

    unique case (r_state)
      StIdle: begin
        w_start = i_note_on;
      end
      StFill: begin
        o_mem_we    = 1'b1;
        o_mem_addr  = r_ptr;
        o_mem_wdata = r_lfsr[DW-1:0];
        w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        if (r_ptr == r_n - AW'(1)) begin
          w_ptr_nxt   = '0;
          w_ph_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (r_dur == '0) ? StDone : StPlay;
        end else begin
          w_ptr_nxt = r_ptr + AW'(1);
        end
      end
      StPlay: begin
        o_mem_addr = r_ptr;
        w_ph_nxt   = (r_ph == PhLast) ? '0 : r_ph + PhW'(1);
        if (r_ph == PhRead) begin
          w_flt_in_nxt    = i_mem_rdata;
          w_smp_out_nxt   = i_mem_rdata;
          w_smp_valid_nxt = 1'b1;
        end
        if (r_ph == PhWrite) begin
          o_mem_we    = 1'b1;
          o_mem_wdata = i_flt_out;
          w_ptr_nxt   = w_ptr_wrap;
          w_cnt_nxt   = (r_cnt == r_dur) ? r_cnt : r_cnt + DURW'(1);
        end
        // With Div == 4 the last phase is the write phase, so test the updated count.
        if (r_ph == PhLast && w_cnt_nxt == r_dur) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        o_done      = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

`ifdef RETRIGGER_EN
    if ((r_state == StFill || r_state == StPlay) && i_note_on) begin
      w_start = 1'b1;
    end
`else
`endif

    if (w_start) begin
      w_state_nxt     = StFill;
      w_n_nxt         = w_len_clamp;
      w_dur_nxt       = i_note_dur;
      w_ptr_nxt       = '0;
      w_cnt_nxt       = '0;
      w_ph_nxt        = '0;
      w_smp_valid_nxt = 1'b0;
    end
  end

  assign o_flt_in    = r_flt_in;
  assign o_smp_out   = r_smp_out;
  assign o_smp_valid = r_smp_valid;

endmodule

// File: tb/tb_ks_voice_ctrl.sv
// Directed + random notes against a string-level reference model of the voice,
// with behavioural delay-line RAM and two-tap averaging filter around the DUT.
module tb_ks_voice_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int DURW = 16;
  localparam int DIV  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            note_on;
  logic [AW-1:0]   note_len;
  logic [DURW-1:0] note_dur;
  logic            busy, done, mem_we, smp_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata, flt_in, flt_out, smp_out, f_prev;
  logic [DW-1:0]   ram [256];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0]   m_lfsr;
  logic [DW-1:0] m_prev;
  int q_fa[$], q_fd[$], q_wa[$], q_wd[$], q_smp[$];

  always #5 clk = ~clk;

  ks_voice_ctrl #(.DW(DW), .AW(AW), .SMP_DIV(DIV), .DURW(DURW)) dut (
    .i_clok(clk), .i_rst(rst), .i_note_on(note_on), .i_note_len(note_len),
    .i_note_dur(note_dur), .o_busy(busy), .o_done(done), .o_mem_addr(mem_addr),
    .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_flt_in(flt_in), .i_flt_out(flt_out), .o_smp_out(smp_out), .o_smp_valid(smp_valid)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      f_prev  <= '0;
      flt_out <= '0;
    end else begin
      flt_out <= DW'(({1'b0, flt_in} + {1'b0, f_prev}) >> 1);
      f_prev  <= flt_in;
    end
  end

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q_fa.delete(); q_fd.delete(); q_wa.delete(); q_wd.delete(); q_smp.delete();
  endtask

  // String-level model: fill with noise, then each played sample is replaced
  // by the mean of itself and the previously played sample.
  task automatic build_model(int len, int dur);
    int n;
    int x, y, a;
    logic [DW-1:0] s [256];
    n = (len < 2) ? 2 : len;
    for (int i = 0; i < n; i++) begin
      s[i] = m_lfsr[DW-1:0];
      q_fa.push_back(i);
      q_fd.push_back(int'(m_lfsr[DW-1:0]));
      m_lfsr = lfsr_next(m_lfsr);
    end
    for (int k = 0; k < dur; k++) begin
      a = k % n;
      x = int'(s[a]);
      q_smp.push_back(x);
      y = (x + int'(m_prev)) / 2;
      m_prev = DW'(x);
      s[a] = DW'(y);
      q_wa.push_back(a);
      q_wd.push_back(y);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    note_on = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    m_prev = '0;
    clear_model();
  endtask

  task automatic run_note(int len, int dur, bit poke, bit check_e1);
    int  budget, n_done, last_smp;
    bit  finished, poked;
    int  eff_dur;
    eff_dur = dur;
`ifdef RETRIGGER_EN
    if (poke) eff_dur = 1;
`endif
    clear_model();
    build_model(len, eff_dur);
    @(negedge clk);
    note_len = AW'(len);
    note_dur = DURW'(dur);
    note_on  = 1'b1;
    budget   = 100 + 3 * len + 6 * DIV * (dur + 2);
    n_done   = 0;
    last_smp = -1;
    finished = 1'b0;
    poked    = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      note_on = 1'b0;
      if (cyc == 0) begin
        chk("busy_first", busy, 1);
        if (check_e1) chk("first_wdata", mem_wdata, 8'hE1);
      end
      if (mem_we) begin
        if (q_fa.size() > 0) begin
          chk("fill_addr", mem_addr, q_fa.pop_front());
          chk("fill_data", mem_wdata, q_fd.pop_front());
        end else if (q_wa.size() > 0) begin
          chk("wb_addr", mem_addr, q_wa.pop_front());
          chk("wb_data", mem_wdata, q_wd.pop_front());
          if (poke && !poked) begin
            poked = 1'b1;
            last_smp = -1;
`ifdef RETRIGGER_EN
            build_model(5, 2);
`endif
            note_len = AW'(5);
            note_dur = DURW'(2);
            note_on  = 1'b1;
          end
        end else begin
          chk("spurious_we", 1, 0);
        end
      end
      if (smp_valid) begin
        if (q_smp.size() > 0) chk("smp_out", smp_out, q_smp.pop_front());
        else chk("spurious_valid", 1, 0);
        if (last_smp >= 0) chk("smp_gap", cyc - last_smp, DIV);
        last_smp = cyc;
      end
      if (done) begin
        n_done++;
        chk("busy_at_done", busy, 1);
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    chk("note_finished", finished, 1);
    chk("fill_left", q_fa.size(), 0);
    chk("wb_left", q_wa.size(), 0);
    chk("smp_left", q_smp.size(), 0);
    chk("done_count", n_done, 1);
    chk("done_low_after", done, 0);
    if (!finished) do_reset();
  endtask

  initial begin
    int  len, dur;
    bit  hit;
    rst = 1'b1; note_on = 1'b0; note_len = '0; note_dur = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_smp", smp_out, 0);
    chk("rst_flt_in", flt_in, 0);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    m_prev = '0;

    run_note(4, 3, 1'b0, 1'b1);
    run_note(3, 7, 1'b0, 1'b0);
    run_note(0, 2, 1'b0, 1'b0);
    run_note(1, 0, 1'b0, 1'b0);

    // Reset on the first write-back cycle of a note.
    @(negedge clk);
    note_len = AW'(4); note_dur = DURW'(3); note_on = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      note_on = 1'b0;
      if (cyc >= 4 && mem_we) begin
        hit = 1'b1;
        break;
      end
    end
    chk("wb_reached", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", smp_valid, 0);
    rst = 1'b0;
    m_lfsr = 16'hACE1;
    m_prev = '0;
    run_note(4, 3, 1'b0, 1'b1);

    run_note(4, 3, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      len = int'($urandom_range(0, 10));
      dur = int'($urandom_range(0, 9));
      run_note(len, dur, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
